// File: rtl/mac_sequencer.sv
// mac_sequencer: initiator for the combinational signed_multiplier MAC datapath.
// Accepts LEN weight/value pairs over valid/ready, chains each multiplier
// result back into the accumulator, and presents one dot-product result with a
// sticky overflow flag. Mode (int8 / fp8 E4M3) is latched per dot product.
// Optional feature: define MAC_SEQ_ABORT_EN to add the `abort` input, which
// drops an in-flight dot product (ACCUM or DONE) back to IDLE with no result.
module mac_sequencer #(
  parameter int LEN   = 8,
  parameter int CNT_W = $clog2(LEN + 1)
) (
  input  logic       clk,
  input  logic       rst,
`ifdef MAC_SEQ_ABORT_EN
  input  logic       abort,
`endif
  input  logic       start,
  input  logic       float_mode,
  input  logic [7:0] bias,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_weight,
  input  logic [7:0] in_value,
  output logic [7:0] mul_weight,
  output logic [7:0] mul_value,
  output logic [7:0] mul_cumulative,
  output logic       mul_float,
  input  logic [7:0] mul_out,
  input  logic       mul_overflow,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_overflow,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t           state;
  logic [7:0]       acc;
  logic             mode;
  logic             ovf;
  logic [CNT_W-1:0] cnt;
  logic             abort_req;
  logic             last_pair;

`ifdef MAC_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign last_pair = (cnt == CNT_W'(LEN - 1));

  // Operands reach the multiplier only while accepting pairs; zero otherwise
  // so the datapath does not toggle on idle bus traffic. in_ready is high
  // exactly in ACCUM, so it doubles as the state qualifier here.
  assign mul_weight     = in_ready ? in_weight : 8'h00;
  assign mul_value      = in_ready ? in_value  : 8'h00;
  assign mul_cumulative = acc;
  assign mul_float      = mode;
  assign res_data       = acc;
  assign res_overflow   = ovf;

  // Control FSM with registered handshake/status outputs and the datapath registers.
  // NOTE: every register here is state, so all assignments are non-blocking;
  // blocking ones would let later statements see same-edge updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= 8'h00;
      mode      <= 1'b0;
      ovf       <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= bias;
            mode     <= float_mode;
            ovf      <= 1'b0;
            cnt      <= '0;
            state    <= ACCUM;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ACCUM: begin
          if (abort_req) begin
            // Abort wins over a pair offered in the same cycle; acc/ovf keep
            // whatever partial value they had.
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end else if (in_valid) begin
            acc <= mul_out;
            ovf <= ovf | mul_overflow;
            cnt <= cnt + CNT_W'(1);
            if (last_pair) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              res_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (abort_req || res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Testbench for mac_sequencer (LEN=4). Provides a behavioural stand-in for the
// combinational signed_multiplier, a transaction-level reference model (the
// expected accumulator is a fold of the accepted pairs from the bias), a
// per-cycle compare process, directed scenarios with literal expectations and
// a randomized phase.
module tb_mac_sequencer;

  localparam int LEN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       abort = 1'b0;
  logic       start = 1'b0;
  logic       float_mode = 1'b0;
  logic [7:0] bias = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_weight = 8'h00;
  logic [7:0] in_value = 8'h00;
  logic [7:0] mul_weight;
  logic [7:0] mul_value;
  logic [7:0] mul_cumulative;
  logic       mul_float;
  logic [7:0] mul_out;
  logic       mul_overflow;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [7:0] res_data;
  logic       res_overflow;
  logic       busy;

  int passed = 0;
  int total  = 0;

  mac_sequencer #(.LEN(LEN)) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef MAC_SEQ_ABORT_EN
    .abort          (abort),
`endif
    .start          (start),
    .float_mode     (float_mode),
    .bias           (bias),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_weight      (in_weight),
    .in_value       (in_value),
    .mul_weight     (mul_weight),
    .mul_value      (mul_value),
    .mul_cumulative (mul_cumulative),
    .mul_float      (mul_float),
    .mul_out        (mul_out),
    .mul_overflow   (mul_overflow),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_overflow   (res_overflow),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // ---------------- multiplier stand-in ----------------
  function automatic real pow2(input int k);
    real p = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) p = p * 2.0;
    else        for (int i = 0; i < -k; i++) p = p / 2.0;
    return p;
  endfunction

  function automatic real fp8_dec(input logic [7:0] x);
    int  e = int'(x[6:3]);
    int  m = int'(x[2:0]);
    real mag;
    if (e == 0) mag = real'(m) * pow2(-9);
    else        mag = (1.0 + real'(m) / 8.0) * pow2(e - 7);
    return x[7] ? -mag : mag;
  endfunction

  // Round-to-nearest (ties to even code) by searching all finite magnitudes;
  // magnitudes above 448 saturate and flag overflow.
  function automatic logic [8:0] fp8_enc(input real r);
    real        mag = (r < 0.0) ? -r : r;
    real        best_d = 1.0e30;
    logic [7:0] best = 8'h00;
    logic [7:0] c;
    real        d;
    if (mag > 448.0) return {1'b1, (r < 0.0) ? 8'hFE : 8'h7E};
    for (int i = 0; i < 127; i++) begin
      c = 8'(i);
      d = fp8_dec(c) - mag;
      if (d < 0.0) d = -d;
      if (d < best_d || (d == best_d && c[0] == 1'b0)) begin
        best_d = d;
        best   = c;
      end
    end
    if (r < 0.0 && best != 8'h00) best[7] = 1'b1;
    return {1'b0, best};
  endfunction

  // Returns {overflow, out}.
  function automatic logic [8:0] mac(input logic [7:0] w, input logic [7:0] v,
                                     input logic [7:0] c, input logic f);
    int a, b, s, k;
    if (f) return fp8_enc(fp8_dec(w) * fp8_dec(v) + fp8_dec(c));
    a = $signed(w);
    b = $signed(v);
    k = $signed(c);
    s = a * b + k;
    if (s > 127)  return {1'b1, 8'h7F};
    if (s < -128) return {1'b1, 8'h80};
    return {1'b0, 8'(s)};
  endfunction

  always_comb begin
    {mul_overflow, mul_out} = mac(mul_weight, mul_value, mul_cumulative, mul_float);
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] w;
    logic [7:0] v;
  } pair_t;

  pair_t      pairs[$];
  bit         m_active = 1'b0;
  bit         m_done = 1'b0;
  logic [7:0] m_bias = 8'h00;
  logic       m_mode = 1'b0;

  // Transaction view: a dot product is active from an accepted start until its
  // result is taken (or aborted); pairs are collected until LEN are held.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_active = 1'b0;
        m_done   = 1'b0;
        m_bias   = 8'h00;
        m_mode   = 1'b0;
        pairs.delete();
      end else if (!m_active) begin
        if (start) begin
          m_active = 1'b1;
          m_done   = 1'b0;
          m_bias   = bias;
          m_mode   = float_mode;
          pairs.delete();
        end
      end else if (abort) begin
        m_active = 1'b0;
        m_done   = 1'b0;
      end else if (!m_done) begin
        if (in_valid) begin
          pairs.push_back('{w: in_weight, v: in_value});
          if (pairs.size() == LEN) m_done = 1'b1;
        end
      end else if (res_ready) begin
        m_active = 1'b0;
        m_done   = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle compare: the accumulator must equal the fold of accepted pairs.
  initial begin
    logic [7:0] e_acc;
    logic       e_ovf;
    logic [8:0] r;
    bit         e_rdy;
    forever begin
      @(negedge clk);
      e_acc = m_bias;
      e_ovf = 1'b0;
      foreach (pairs[i]) begin
        r     = mac(pairs[i].w, pairs[i].v, e_acc, m_mode);
        e_acc = r[7:0];
        e_ovf = e_ovf | r[8];
      end
      e_rdy = m_active && !m_done;
      check("in_ready",       32'(in_ready),       32'(e_rdy));
      check("res_valid",      32'(res_valid),      32'(m_done));
      check("busy",           32'(busy),           32'(m_active));
      check("res_data",       32'(res_data),       32'(e_acc));
      check("res_overflow",   32'(res_overflow),   32'(e_ovf));
      check("mul_cumulative", 32'(mul_cumulative), 32'(e_acc));
      check("mul_float",      32'(mul_float),      32'(m_mode));
      check("mul_weight",     32'(mul_weight),     32'(e_rdy ? in_weight : 8'h00));
      check("mul_value",      32'(mul_value),      32'(e_rdy ? in_value : 8'h00));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_dp(input logic [7:0] b, input logic f);
    start      = 1'b1;
    bias       = b;
    float_mode = f;
    tick();
    start      = 1'b0;
  endtask

  task automatic send(input logic [7:0] w, input logic [7:0] v);
    in_valid  = 1'b1;
    in_weight = w;
    in_value  = v;
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] w1[4];
    logic [7:0] v1[4];
    logic [7:0] fexp[4];
    logic [7:0] held;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_res_data", 32'(res_data), 32'h00);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_mul_cum", 32'(mul_cumulative), 32'h00);
    rst = 1'b0;
    tick();

    // Int dot product, back-to-back pairs; start with in_valid does not consume
    w1 = '{8'h02, 8'hFF, 8'h0A, 8'h00};
    v1 = '{8'h03, 8'h04, 8'h02, 8'h07};
    in_valid = 1'b1;
    start_dp(8'h05, 1'b0);
    check("t1_ready_after_start", 32'(in_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("t1_no_result_yet", 32'(res_valid), 32'h0);
      send(w1[i], v1[i]);
    end
    check("t1_res_valid", 32'(res_valid), 32'h1);
    check("t1_res_data", 32'(res_data), 32'h1B);
    check("t1_res_ovf", 32'(res_overflow), 32'h0);
    tick();
    check("t1_back_idle", 32'(busy), 32'h0);
    check("t1_data_held_idle", 32'(res_data), 32'h1B);

    // Int overflow is sticky
    start_dp(8'h00, 1'b0);
    send(8'h7F, 8'h7F);
    for (int i = 0; i < 3; i++) send(8'h00, 8'h00);
    check("t2_res_data", 32'(res_data), 32'h7F);
    check("t2_res_ovf", 32'(res_overflow), 32'h1);
    tick();

    // fp8 accumulation 1.0 + 4 * 2.0
    fexp = '{8'h44, 8'h4A, 8'h4E, 8'h51};
    start_dp(8'h38, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("t3_mul_float", 32'(mul_float), 32'h1);
      send(8'h40, 8'h38);
      check("t3_acc_step", 32'(mul_cumulative), 32'(fexp[i]));
    end
    check("t3_res_data", 32'(res_data), 32'h51);
    tick();

    // Backpressure on both sides
    w1 = '{8'h03, 8'hFE, 8'h01, 8'h04};
    v1 = '{8'h03, 8'h02, 8'h01, 8'hFC};
    start_dp(8'h10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(w1[i], v1[i]);
      if (i < 3) tick();
    end
    res_ready = 1'b0;
    start = 1'b1;
    held = res_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_valid_held", 32'(res_valid), 32'h1);
      check("t4_data_held", 32'(res_data), 32'(held));
      check("t4_busy", 32'(busy), 32'h1);
    end
    check("t4_res_data", 32'(res_data), 32'h06);
    start = 1'b0;
    res_ready = 1'b1;
    tick();
    tick();

    // Reset mid-operation, then restart
    start_dp(8'h22, 1'b1);
    send(8'h01, 8'h01);
    send(8'h01, 8'h01);
    rst = 1'b1;
    #1;
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_ready", 32'(in_ready), 32'h0);
    check("t5_rst_data", 32'(res_data), 32'h00);
    check("t5_rst_float", 32'(mul_float), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    start_dp(8'h00, 1'b0);
    for (int i = 0; i < 4; i++) send(8'h01, 8'h01);
    check("t5_res_data", 32'(res_data), 32'h04);
    check("t5_res_ovf", 32'(res_overflow), 32'h0);
    tick();

`ifdef MAC_SEQ_ABORT_EN
    // Abort during the third handshake
    start_dp(8'h00, 1'b0);
    send(8'h01, 8'h02);
    send(8'h01, 8'h02);
    abort = 1'b1;
    send(8'h01, 8'h02);
    abort = 1'b0;
    check("t6_abort_ready", 32'(in_ready), 32'h0);
    check("t6_abort_valid", 32'(res_valid), 32'h0);
    check("t6_abort_busy", 32'(busy), 32'h0);
    check("t6_abort_acc", 32'(res_data), 32'h04);
    tick();
    check("t6_no_pulse", 32'(res_valid), 32'h0);
`endif

    // Randomized traffic checked by the per-cycle compare
    for (int n = 0; n < 3000; n++) begin
      start      = ($urandom_range(0, 7) == 0);
      float_mode = 1'($urandom_range(0, 1));
      bias       = 8'($urandom);
      in_valid   = 1'($urandom_range(0, 1));
      in_weight  = 8'($urandom);
      in_value   = 8'($urandom);
      res_ready  = 1'($urandom_range(0, 1));
`ifdef MAC_SEQ_ABORT_EN
      abort      = ($urandom_range(0, 15) == 0);
`endif
      rst        = ($urandom_range(0, 499) == 0);
      tick();
      rst        = 1'b0;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    abort    = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Sequential controller that drives the combinational `signed_multiplier` MAC datapath as its initiator. It accepts a stream of weight/value pairs over a valid/ready handshake and feeds each pair with the running accumulator into the multiplier's `cumulative` input. It captures the multiplier's `out` back into the accumulator and, after `LEN` pairs, presents one dot-product result with a sticky overflow flag. Mode is int8 or fp8 (E4M3, bias 7), fixed per dot product.

## Interface
- `LEN`, 8, pairs per dot product (≥1)
- `CNT_W`, $clog2(LEN+1), pair-counter width
- `clk`  in  1  clock
- `rst`  in  1  asynchronous reset, active-high
- `start`  in  1  begin dot product; honoured only in IDLE
- `float_mode`  in  1  sampled on accepted `start`; 1 = fp8, 0 = int8
- `bias`  in  8  initial accumulator, sampled on accepted `start`
- `in_valid`  in  1  pair valid
- `in_ready`  out  1  sequencer accepts pair
- `in_weight`  in  8  weight operand
- `in_value`  in  8  value operand
- `mul_weight`  out  8  to multiplier `weight`
- `mul_value`  out  8  to multiplier `value`
- `mul_cumulative`  out  8  to multiplier `cumulative` (accumulator register)
- `mul_float`  out  1  to multiplier `float` (mode register)
- `mul_out`  in  8  from multiplier `out`
- `mul_overflow`  in  1  from multiplier `overflow`
- `res_valid`  out  1  result valid
- `res_ready`  in  1  downstream accepts result
- `res_data`  out  8  final accumulator
- `res_overflow`  out  1  OR of `mul_overflow` over all accepted pairs
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - `in_ready`=0, `res_valid`=0.
  - On `start`: acc←`bias`, mode←`float_mode`, cnt←0, ovf←0, go to ACCUM.
- ACCUM:
  - `in_ready`=1. `mul_weight`/`mul_value` are combinational copies of `in_weight`/`in_value`; `mul_cumulative`=acc; `mul_float`=mode.
  - On `in_valid`&&`in_ready`: acc←`mul_out`, ovf←ovf|`mul_overflow`, cnt←cnt+1.
  - If cnt==LEN-1 at the handshake, go to DONE.
- DONE:
  - `res_valid`=1, `res_data`=acc, `res_overflow`=ovf. Both are held stable until `res_ready`.
  - On `res_ready`, go to IDLE.
- Outside ACCUM, `mul_weight`=`mul_value`=0, which limits multiplier toggling. `mul_cumulative` and `mul_float` always reflect the registers.
- `start` is ignored in ACCUM and DONE.
- The sequencer does not modify arithmetic. Saturated int results (0x7F/0x80) and fp8 rounding come from the multiplier and are carried forward as-is.
- `res_data`/`res_overflow` keep their last values in IDLE until the next `start` reloads acc/ovf.

## Timing
- Reset values:
  - State IDLE; acc, cnt, mode, ovf all 0.
  - Outputs: `in_ready`=0, `res_valid`=0, `res_data`=0x00, `res_overflow`=0, `busy`=0, all `mul_*`=0.
- `start` accepted at edge N: `in_ready`=1 from cycle N+1.
- A `start` asserted with `in_valid` in the same cycle does not consume the pair.
- Throughput is one pair per cycle; the multiplier path is combinational within the cycle.
- `res_valid` rises the cycle after the LEN-th handshake.
- Minimum dot product: 1 + LEN + 1 cycles, with `res_ready` held high.
- `res_ready` low stalls DONE indefinitely; no pairs are accepted meanwhile.
- `rst` mid-operation: immediate return to reset values; any partial result is discarded.

## Configuration
- `MAC_SEQ_ABORT_EN` defined: adds input `abort` (1 bit).
  - `abort` high in ACCUM or DONE returns to IDLE at the next edge with no result.
  - `abort` beats a simultaneous pair handshake or `res_ready`; acc/ovf are left as-is.
- Undefined: no `abort` port; a dot product completes only via LEN pairs plus result acceptance.

## Test plan
- Int, LEN=4, bias 0x05, pairs (0x02,0x03),(0xFF,0x04),(0x0A,0x02),(0x00,0x07) back-to-back, `res_ready`=1 -> `res_data`=0x1B, `res_overflow`=0, `res_valid` one cycle after 4th handshake.
- Int overflow: bias 0x00, pair (0x7F,0x7F) then three (0x00,0x00) -> `res_data`=0x7F, `res_overflow`=1.
- Fp8, bias 0x38 (1.0), four pairs (0x40,0x38) -> acc sequence 0x44,0x4A,0x4E,0x51; `res_data`=0x51 (9.0), `mul_float`=1 throughout ACCUM.
- Backpressure: `in_valid` toggled 1/0 each cycle, then `res_ready` low 5 cycles with `start` pulsed -> correct result, `res_valid`/`res_data` stable, `start` ignored, `busy`=1.
- Reset after 2 of 4 pairs -> all outputs at reset values next cycle; new `start` with bias 0x00 and four (0x01,0x01) -> 0x04, `res_overflow`=0.
- With `MAC_SEQ_ABORT_EN`: `abort` during the 3rd pair's handshake -> IDLE next cycle, no `res_valid` pulse, `in_ready`=0.
